// File: rtl/mem_stage.sv
// Memory stage: word loads/stores against a local data RAM with a fixed access
// latency, stall request while waiting, and the registered MEM/WB bundle.
module mem_stage #(
  parameter int ADDR_WIDTH  = 10,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] result_i,
  input  logic [31:0] read_data2_i,
  input  logic        wb_sel_i,
  input  logic        reg_write_enable_i,
  input  logic        mem_write_enable_i,
  input  logic [4:0]  reg_write_dst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] reg_write_data_o,
  output logic        reg_write_enable_o,
  output logic [4:0]  reg_write_dst_o,
  output logic        m_valid_o,
  output logic [4:0]  m_dest_reg_o
);

  logic [2:0]            cnt;
  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  mem_op;
  logic                  last;
  logic                  capture;
  logic                  unused_bits;

  assign mem_op      = mem_write_enable_i | (wb_sel_i & reg_write_enable_i);
  assign idx         = result_i[ADDR_WIDTH+1:2];
  assign unused_bits = ^{result_i[31:ADDR_WIDTH+2], result_i[1:0]};
  assign last        = (cnt == 3'(MEM_LATENCY - 1));
  assign stall_o     = mem_op & ~flush_i & ~last;
  assign capture     = ~flush_i & ~stall_o & ~stall_i;

  assign m_valid_o    = reg_write_enable_o;
  assign m_dest_reg_o = reg_write_dst_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= 3'd0;
    end else if (flush_i) begin
      cnt <= 3'd0;
    end else if (stall_o) begin
      cnt <= cnt + 3'd1;
    end else if (mem_op && last && !stall_i) begin
      cnt <= 3'd0;
    end
  end

  // cnt sits at 0 during reset, so a store never reaches its commit edge there.
  always_ff @(posedge clk_i) begin
    if (capture && mem_write_enable_i) begin
      ram[idx] <= read_data2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_write_data_o   <= 32'd0;
      reg_write_enable_o <= 1'b0;
      reg_write_dst_o    <= 5'd0;
    end else if (flush_i || stall_o) begin
      reg_write_enable_o <= 1'b0;
    end else if (!stall_i) begin
      reg_write_enable_o <= reg_write_enable_i & ~mem_write_enable_i;
      reg_write_dst_o    <= reg_write_dst_i;
      reg_write_data_o   <= wb_sel_i ? ram[idx] : result_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at latency 2, one at latency 4,
// with stimulus steered to whichever instance the current scenario targets.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] result, rd2;
  logic        wb_sel, rwe, mwe, flush, stall_in;
  logic [4:0]  dst_in;
  logic        sel4;

  logic [31:0] wd2, wd4, wd;
  logic        we2, we4, we, st2, st4, stall, mv2, mv4, mv;
  logic [4:0]  dst2, dst4, dst, md2, md4, md;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(10), .MEM_LATENCY(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .result_i(result), .read_data2_i(rd2),
    .wb_sel_i(wb_sel & ~sel4), .reg_write_enable_i(rwe & ~sel4),
    .mem_write_enable_i(mwe & ~sel4), .reg_write_dst_i(dst_in),
    .stall_i(stall_in & ~sel4), .flush_i(flush & ~sel4), .stall_o(st2),
    .reg_write_data_o(wd2), .reg_write_enable_o(we2), .reg_write_dst_o(dst2),
    .m_valid_o(mv2), .m_dest_reg_o(md2)
  );

  mem_stage #(.ADDR_WIDTH(10), .MEM_LATENCY(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .result_i(result), .read_data2_i(rd2),
    .wb_sel_i(wb_sel & sel4), .reg_write_enable_i(rwe & sel4),
    .mem_write_enable_i(mwe & sel4), .reg_write_dst_i(dst_in),
    .stall_i(stall_in & sel4), .flush_i(flush & sel4), .stall_o(st4),
    .reg_write_data_o(wd4), .reg_write_enable_o(we4), .reg_write_dst_o(dst4),
    .m_valid_o(mv4), .m_dest_reg_o(md4)
  );

  assign wd    = sel4 ? wd4  : wd2;
  assign we    = sel4 ? we4  : we2;
  assign dst   = sel4 ? dst4 : dst2;
  assign stall = sel4 ? st4  : st2;
  assign mv    = sel4 ? mv4  : mv2;
  assign md    = sel4 ? md4  : md2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    wb_sel = 1'b0; rwe = 1'b0; mwe = 1'b0; flush = 1'b0; stall_in = 1'b0;
    result = 32'd0; rd2 = 32'd0; dst_in = 5'd0;
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [31:0] data);
    wb_sel = 1'b0; rwe = 1'b0; mwe = 1'b1; result = addr; rd2 = data; dst_in = 5'd0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] d);
    wb_sel = 1'b1; rwe = 1'b1; mwe = 1'b0; result = addr; rd2 = 32'd0; dst_in = d;
  endtask

  task automatic run_op(input bit is_store, input logic [31:0] addr,
                        input logic [31:0] data, input int n);
    if (is_store) set_store(addr, data);
    else          set_load(addr, 5'd0);
    repeat (n) tick();
    set_idle();
  endtask

  task automatic test_reset;
    sel4 = 1'b1;
    rst_n = 1'b0;
    set_idle();
    repeat (2) tick();
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL rst_we got=%0h want=0", we); end
    total++; if (wd !== 32'd0) begin bad++; $display("[TB] FAIL rst_wd got=%08h want=00000000", wd); end
    total++; if (dst !== 5'd0) begin bad++; $display("[TB] FAIL rst_dst got=%0d want=0", dst); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%0h want=0", stall); end
    total++; if (mv !== 1'b0) begin bad++; $display("[TB] FAIL rst_mvalid got=%0h want=0", mv); end
    rst_n = 1'b1;
    tick();
    run_op(1'b1, 32'h100, 32'hCAFE_F00D, 4);
    set_store(32'h100, 32'h5555_5555);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL rst_store_stall got=%0h want=1", stall); end
    repeat (2) tick();
    rst_n = 1'b0;
    set_idle();
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_we got=%0h want=0", we); end
    total++; if (wd !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_wd got=%08h want=00000000", wd); end
    total++; if (dst !== 5'd0) begin bad++; $display("[TB] FAIL rstmid_dst got=%0d want=0", dst); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_stall got=%0h want=0", stall); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    set_load(32'h100, 5'd12);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (stall !== (c < 3)) begin
        bad++; $display("[TB] FAIL rst_load_stall c%0d got=%0h want=%0h", c, stall, (c < 3));
      end
      tick();
    end
    set_idle();
    total++; if (wd !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL rst_abort_data got=%08h want=cafef00d", wd); end
    total++; if (we !== 1'b1) begin bad++; $display("[TB] FAIL rst_abort_we got=%0h want=1", we); end
  endtask

  task automatic test_alu;
    sel4 = 1'b0;
    set_idle();
    result = 32'h1234_5678; rwe = 1'b1; dst_in = 5'd7;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL alu_stall got=%0h want=0", stall); end
    tick();
    set_idle();
    total++; if (wd !== 32'h1234_5678) begin bad++; $display("[TB] FAIL alu_wd got=%08h want=12345678", wd); end
    total++; if (we !== 1'b1) begin bad++; $display("[TB] FAIL alu_we got=%0h want=1", we); end
    total++; if (dst !== 5'd7) begin bad++; $display("[TB] FAIL alu_dst got=%0d want=7", dst); end
    total++; if (mv !== 1'b1) begin bad++; $display("[TB] FAIL alu_mvalid got=%0h want=1", mv); end
    total++; if (md !== 5'd7) begin bad++; $display("[TB] FAIL alu_mdest got=%0d want=7", md); end
  endtask

  task automatic test_store_load;
    logic [31:0] addrs [2];
    sel4 = 1'b0;
    set_store(32'h40, 32'hDEAD_BEEF);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL st_stall0 got=%0h want=1", stall); end
    tick();
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL st_we1 got=%0h want=0", we); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL st_stall1 got=%0h want=0", stall); end
    tick();
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL st_we_done got=%0h want=0", we); end
    addrs[0] = 32'h40; addrs[1] = 32'h42;
    for (int i = 0; i < 2; i++) begin
      set_load(addrs[i], 5'(3 + i));
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL ld%0d_stall0 got=%0h want=1", i, stall); end
      tick();
      total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL ld%0d_we1 got=%0h want=0", i, we); end
      tick();
      total++; if (wd !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL ld%0d_wd got=%08h want=deadbeef", i, wd); end
      total++; if (dst !== 5'(3 + i)) begin bad++; $display("[TB] FAIL ld%0d_dst got=%0d want=%0d", i, dst, 3 + i); end
    end
    set_idle();
  endtask

  task automatic test_flush;
    sel4 = 1'b1;
    run_op(1'b1, 32'h80, 32'hAAAA_0000, 4);
    set_store(32'h80, 32'h0000_0001);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL fl_stall0 got=%0h want=1", stall); end
    tick();
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL fl_stall_drop got=%0h want=0", stall); end
    tick();
    flush = 1'b0;
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL fl_bubble got=%0h want=0", we); end
    set_load(32'h80, 5'd9);
    repeat (2) tick();
    total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL fl_ld_stall2 got=%0h want=1", stall); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL fl_ld_stall3 got=%0h want=0", stall); end
    tick();
    set_idle();
    total++; if (wd !== 32'hAAAA_0000) begin bad++; $display("[TB] FAIL fl_ld_wd got=%08h want=aaaa0000", wd); end
    total++; if (we !== 1'b1) begin bad++; $display("[TB] FAIL fl_ld_we got=%0h want=1", we); end
    total++; if (dst !== 5'd9) begin bad++; $display("[TB] FAIL fl_ld_dst got=%0d want=9", dst); end
  endtask

  task automatic test_ext_stall;
    sel4 = 1'b0;
    set_idle();
    result = 32'h0BAD_C0DE; rwe = 1'b1; dst_in = 5'd2;
    tick();
    set_load(32'h40, 5'd6);
    tick();
    stall_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL xs_stallo c%0d got=%0h want=0", c, stall); end
      tick();
      total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL xs_hold_we c%0d got=%0h want=0", c, we); end
      total++; if (dst !== 5'd2) begin bad++; $display("[TB] FAIL xs_hold_dst c%0d got=%0d want=2", c, dst); end
    end
    stall_in = 1'b0;
    tick();
    total++; if (wd !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL xs_ld_wd got=%08h want=deadbeef", wd); end
    total++; if (we !== 1'b1) begin bad++; $display("[TB] FAIL xs_ld_we got=%0h want=1", we); end
    total++; if (dst !== 5'd6) begin bad++; $display("[TB] FAIL xs_ld_dst got=%0d want=6", dst); end
    set_store(32'h60, 32'h0000_0077);
    tick();
    stall_in = 1'b1;
    repeat (3) tick();
    stall_in = 1'b0;
    tick();
    total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL xs_st_we got=%0h want=0", we); end
    set_load(32'h60, 5'd8);
    repeat (2) tick();
    set_idle();
    total++; if (wd !== 32'h0000_0077) begin bad++; $display("[TB] FAIL xs_st_readback got=%08h want=00000077", wd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    logic [31:0] exp   [4];
    sel4 = 1'b0;
    run_op(1'b1, 32'h1008, 32'h5A5A_1234, 2);
    run_op(1'b1, 32'h44, 32'h0101_0101, 2);
    run_op(1'b1, 32'h48, 32'hF0F0_F0F0, 2);
    addrs[0] = 32'h8;  exp[0] = 32'h5A5A_1234;
    addrs[1] = 32'h40; exp[1] = 32'hDEAD_BEEF;
    addrs[2] = 32'h44; exp[2] = 32'h0101_0101;
    addrs[3] = 32'h48; exp[3] = 32'hF0F0_F0F0;
    for (int i = 0; i < 4; i++) begin
      set_load(addrs[i], 5'(10 + i));
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_stall0 got=%0h want=1", i, stall); end
      tick();
      total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL b2b%0d_we1 got=%0h want=0", i, we); end
      total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b%0d_stall1 got=%0h want=0", i, stall); end
      tick();
      total++; if (wd !== exp[i]) begin bad++; $display("[TB] FAIL b2b%0d_wd got=%08h want=%08h", i, wd, exp[i]); end
      total++; if (dst !== 5'(10 + i)) begin bad++; $display("[TB] FAIL b2b%0d_dst got=%0d want=%0d", i, dst, 10 + i); end
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    sel4 = 1'b1;
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_alu();
    test_store_load();
    test_flush();
    test_ext_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
